aidc_lite_comp_rdma: RTL and testbench

AIDC_LITE_COMP_RDMA -- requirements
Module: aidc_lite_comp_rdma

---
 rtl/aidc_lite_comp_rdma.sv | 178 +++++++++++++++++
 tb/tb_aidc_lite_comp_rdma.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aidc_lite_comp_rdma.sv
// Read-DMA front end for the compressor: fetches a buffer with AHB INCR4 bursts
// and streams the words, in address order, through a small read-data FIFO.
module aidc_lite_comp_rdma #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cfg_src_addr,
    input  logic [31:0] cfg_len,
    input  logic        cfg_start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    input  logic        hready,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata,
    output logic        m_valid,
    output logic [31:0] m_data,
    output logic        m_last,
    input  logic        m_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR} state_t;

    state_t        state;
    logic [29:0]   addr_left;
    logic [29:0]   out_left;
    logic [1:0]    beat;
    logic          data_pend;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] rsv_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   mem [FIFO_DEPTH];

    logic          active;
    logic          push;
    logic          pop;
    logic          bus_err;
    logic          addr_acc;
    logic [CW:0]   committed;
    logic          credit_ok;
    logic          start_burst;

    assign hwrite = 1'b0;
    assign hsize  = 3'b010;
    assign hburst = 3'b011;

    assign m_valid = (fifo_cnt != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;
    assign m_last  = m_valid && (out_left == 30'd1);

    // A burst reserves four FIFO slots up front; rsv_cnt tracks slots reserved
    // for words still on the bus, so a push can never land on a full FIFO.
    always_comb begin
        active      = (state == S_RUN) || (state == S_DRAIN);
        push        = active && data_pend && hready && (hresp == RESP_OKAY);
        pop         = m_valid && m_ready;
        bus_err     = active && data_pend && (hresp == RESP_ERR);
        addr_acc    = htrans[1] && hready;
        committed   = {1'b0, fifo_cnt} + {1'b0, rsv_cnt} + (CW + 1)'(4);
        credit_ok   = (committed <= (CW + 1)'(FIFO_DEPTH));
        start_burst = (state == S_RUN) && !bus_err && credit_ok &&
                      ((htrans == HT_IDLE) ||
                       (addr_acc && (beat == 2'd3) && (addr_left != 30'd1)));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= hrdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            htrans    <= HT_IDLE;
            haddr     <= '0;
            addr_left <= '0;
            out_left  <= '0;
            beat      <= '0;
            data_pend <= 1'b0;
            fifo_cnt  <= '0;
            rsv_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            done <= 1'b0;
            if (hready) data_pend <= htrans[1];
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                out_left <= out_left - 30'd1;
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            rsv_cnt  <= rsv_cnt + (start_burst ? CW'(4) : '0) - CW'(push);

            if (bus_err) begin
                state    <= S_ERR;
                htrans   <= HT_IDLE;
                err      <= 1'b1;
                busy     <= 1'b0;
                fifo_cnt <= '0;
                rsv_cnt  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cfg_start) begin
                            if ((cfg_src_addr[3:0] != 4'd0) || (cfg_len[3:0] != 4'd0)) begin
                                err <= 1'b1;
                            end else if (cfg_len == 32'd0) begin
                                err  <= 1'b0;
                                done <= 1'b1;
                            end else begin
                                err       <= 1'b0;
                                busy      <= 1'b1;
                                haddr     <= cfg_src_addr;
                                addr_left <= cfg_len[31:2];
                                out_left  <= cfg_len[31:2];
                                beat      <= '0;
                                state     <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (start_burst) begin
                            htrans <= HT_NONSEQ;
                            beat   <= '0;
                        end
                        if (addr_acc) begin
                            haddr     <= haddr + 32'd4;
                            addr_left <= addr_left - 30'd1;
                            if (beat == 2'd3) begin
                                if (addr_left == 30'd1) begin
                                    htrans <= HT_IDLE;
                                    state  <= S_DRAIN;
                                end else if (!start_burst) begin
                                    htrans <= HT_IDLE;
                                end
                            end else begin
                                htrans <= HT_SEQ;
                                beat   <= beat + 2'd1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (pop && m_last) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aidc_lite_comp_rdma.sv
// Directed-plus-random bench for aidc_lite_comp_rdma: an AHB slave/stream sink
// process feeds a scoreboard compared against the expected buffer contents.
module tb_aidc_lite_comp_rdma;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_src_addr;
    logic [31:0] cfg_len;
    logic        cfg_start;
    logic        busy, done, err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;

    aidc_lite_comp_rdma #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .cfg_src_addr(cfg_src_addr), .cfg_len(cfg_len),
        .cfg_start(cfg_start), .busy(busy), .done(done), .err(err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Slave / sink / monitor state
    logic [31:0] salt = '0;
    logic [31:0] exp_addr = '0;
    int          ws_pct = 0;
    bit          ready_rand = 0;
    int          err_beat = 0;
    int          err_stage = 0;
    bit          err_idle_ok = 0;
    bit          prev_hready = 1;
    logic [1:0]  prev_htrans = '0;
    logic [31:0] prev_haddr = '0;
    bit          dp_valid = 0;
    logic [31:0] dp_addr = '0;
    int          dp_idx = 0;
    int          acc_cnt = 0;
    int          nonseq_cnt = 0;
    int          addr_bad = 0;
    int          nonidle_cycles = 0;
    int          stab_bad = 0;
    int          mv_after_err = 0;
    int          done_cnt = 0;
    bit          hold_pend = 0;
    logic [31:0] held_data = '0;
    logic        held_last = 0;
    logic [31:0] rx_data[$];
    logic        rx_last[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AHB slave, stream sink and monitor, all acting on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                dp_valid = 0; err_stage = 0; hready = 1; hresp = 2'b00;
                prev_hready = 1; prev_htrans = 2'b00; hold_pend = 0; m_ready = 1;
                continue;
            end
            if (prev_hready) begin
                dp_valid = prev_htrans[1];
                if (prev_htrans[1]) begin
                    acc_cnt++;
                    dp_idx  = acc_cnt;
                    dp_addr = prev_haddr;
                    if (prev_haddr !== exp_addr) addr_bad++;
                    exp_addr = exp_addr + 32'd4;
                    if (prev_htrans == 2'b10) nonseq_cnt++;
                    if ((prev_htrans == 2'b10) != (((acc_cnt - 1) % 4) == 0)) addr_bad++;
                end
            end
            if (err_stage == 1) begin
                err_idle_ok = (htrans === 2'b00);
                hready = 1; hresp = 2'b01; hrdata = $urandom; err_stage = 2;
            end else if (dp_valid && dp_idx == err_beat && err_stage == 0) begin
                hready = 0; hresp = 2'b01; hrdata = $urandom; err_stage = 1;
            end else if (dp_valid) begin
                hready = ($urandom_range(99) >= ws_pct);
                hresp  = 2'b00;
                hrdata = hready ? mem_word(dp_addr) : $urandom;
            end else begin
                hready = 1; hresp = 2'b00; hrdata = $urandom;
            end
            prev_hready = hready;
            prev_htrans = htrans;
            prev_haddr  = haddr;

            if (htrans !== 2'b00) nonidle_cycles++;
            if (hold_pend && (m_valid !== 1'b1 || m_data !== held_data || m_last !== held_last))
                stab_bad++;
            m_ready = ready_rand ? 1'($urandom_range(1)) : 1'b1;
            if (m_valid && m_ready) begin
                rx_data.push_back(m_data);
                rx_last.push_back(m_last);
            end
            hold_pend = m_valid && !m_ready;
            held_data = m_data;
            held_last = m_last;
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1 && m_valid !== 1'b0) mv_after_err++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic prep(input logic [31:0] a, input logic [31:0] s, input int ws,
                        input bit rr, input int eb);
        rx_data.delete(); rx_last.delete();
        exp_addr = a; salt = s; ws_pct = ws; ready_rand = rr;
        err_beat = eb; err_stage = 0; err_idle_ok = 0;
        acc_cnt = 0; nonseq_cnt = 0; addr_bad = 0; nonidle_cycles = 0;
        stab_bad = 0; mv_after_err = 0; done_cnt = 0;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] len);
        cfg_src_addr = a; cfg_len = len; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_time"}, 32'(n < budget), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] base, input int nw);
        chk({tag, "_count"}, 32'(rx_data.size()), 32'(nw));
        for (int i = 0; i < nw && i < rx_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), rx_data[i], mem_word(base + 32'(4 * i)));
            chk($sformatf("%s_last%0d", tag, i), 32'(rx_last[i]), 32'(i == nw - 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_htrans"}, 32'(htrans), 32'd0);
        chk({tag, "_haddr"}, haddr, 32'd0);
        chk({tag, "_mvalid"}, 32'(m_valid), 32'd0);
        chk({tag, "_mlast"}, 32'(m_last), 32'd0);
        chk({tag, "_mdata"}, m_data, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int n;
        rst = 1; cfg_src_addr = '0; cfg_len = '0; cfg_start = 0;
        hready = 1; hresp = 2'b00; hrdata = '0; m_ready = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("hwrite", 32'(hwrite), 32'd0);
        chk("hsize", 32'(hsize), 32'h2);
        chk("hburst", 32'(hburst), 32'h3);
        rst = 0;
        repeat (2) @(negedge clk);

        // Basic transfer, memory word = address
        prep(32'h0001_0000, 32'h0, 0, 0, 0);
        do_start(32'h0001_0000, 32'h40);
        chk("basic_busy", 32'(busy), 32'd1);
        wait_done("basic", 300);
        check_stream("basic", 32'h0001_0000, 16);
        chk("basic_nonseq", 32'(nonseq_cnt), 32'd4);
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk("basic_busy_end", 32'(busy), 32'd0);
        chk("basic_addr", 32'(addr_bad), 32'd0);

        // Backpressure with wait states
        a = $urandom & 32'hFFFF_FFF0;
        prep(a, $urandom, 30, 1, 0);
        do_start(a, 32'h100);
        wait_done("bp", 5000);
        check_stream("bp", a, 64);
        chk("bp_nonseq", 32'(nonseq_cnt), 32'd16);
        chk("bp_addr", 32'(addr_bad), 32'd0);
        chk("bp_stable", 32'(stab_bad), 32'd0);
        chk("bp_done_cnt", 32'(done_cnt), 32'd1);

        // Address wraps through 2^32
        prep(32'hFFFF_FFC0, $urandom, 20, 1, 0);
        do_start(32'hFFFF_FFC0, 32'h80);
        wait_done("wrap", 3000);
        check_stream("wrap", 32'hFFFF_FFC0, 32);
        chk("wrap_addr", 32'(addr_bad), 32'd0);
        chk("wrap_err", 32'(err), 32'd0);

        // Zero length
        prep(32'h0000_2000, 32'h0, 0, 0, 0);
        do_start(32'h0000_2000, 32'h0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("zero_traffic", 32'(nonidle_cycles), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);

        // Misaligned source and length
        prep(32'h0001_0004, 32'h0, 0, 0, 0);
        do_start(32'h0001_0004, 32'h40);
        chk("misal_err", 32'(err), 32'd1);
        chk("misal_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("misal_traffic", 32'(nonidle_cycles), 32'd0);
        chk("misal_done_cnt", 32'(done_cnt), 32'd0);
        chk("misal_err_sticky", 32'(err), 32'd1);
        do_start(32'h0000_1000, 32'h44);
        chk("misal_len_err", 32'(err), 32'd1);
        chk("misal_len_busy", 32'(busy), 32'd0);

        // Bus error on the 6th beat
        prep(32'h0003_0000, $urandom, 0, 0, 6);
        do_start(32'h0003_0000, 32'h40);
        chk("berr_clears_err", 32'(err), 32'd0);
        n = 0;
        while (err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("berr_seen", 32'(n < 300), 32'd1);
        repeat (5) @(negedge clk);
        chk("berr_err", 32'(err), 32'd1);
        chk("berr_busy", 32'(busy), 32'd0);
        chk("berr_done_cnt", 32'(done_cnt), 32'd0);
        chk("berr_htrans_idle", 32'(err_idle_ok), 32'd1);
        chk("berr_no_mvalid", 32'(mv_after_err), 32'd0);
        chk("berr_prefix_len", 32'(rx_data.size() < 6), 32'd1);
        for (int i = 0; i < rx_data.size(); i++)
            chk($sformatf("berr_prefix%0d", i), rx_data[i], mem_word(32'h0003_0000 + 32'(4 * i)));
        prep(32'h0004_0000, $urandom, 10, 1, 0);
        do_start(32'h0004_0000, 32'h20);
        chk("recover_err_clear", 32'(err), 32'd0);
        wait_done("recover", 1000);
        check_stream("recover", 32'h0004_0000, 8);

        // Reset during the 3rd burst
        prep(32'h0005_0000, $urandom, 20, 1, 0);
        do_start(32'h0005_0000, 32'h100);
        n = 0;
        while (acc_cnt < 9 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_burst3", 32'(n < 1000), 32'd1);
        rst = 1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        prep(32'h0006_0000, $urandom, 0, 0, 0);
        do_start(32'h0006_0000, 32'h20);
        wait_done("after_rst", 500);
        check_stream("after_rst", 32'h0006_0000, 8);
        chk("after_rst_addr", 32'(addr_bad), 32'd0);

        // Start while busy is ignored
        prep(32'h0007_0000, $urandom, 10, 1, 0);
        do_start(32'h0007_0000, 32'h80);
        repeat (5) @(negedge clk);
        chk("sb_busy", 32'(busy), 32'd1);
        do_start(32'h0009_0000, 32'h40);
        wait_done("sb", 3000);
        repeat (20) @(negedge clk);
        chk("sb_done_cnt", 32'(done_cnt), 32'd1);
        check_stream("sb", 32'h0007_0000, 32);
        chk("sb_addr", 32'(addr_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
